// File: rtl/decode_stage.sv
// Decode stage: register file, immediate generator, write-back bypass,
// RAW scoreboard and a valid/ready output register feeding execute.
module decode_stage #(
  parameter int          XLEN    = 32,
  parameter int          NREG    = 32,
  parameter int unsigned SP_INIT = 65536,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             inst,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_rs1_data,
  output logic [XLEN-1:0]         out_rs2_data,
  output logic [$clog2(NREG)-1:0] out_rd,
  output logic [XLEN-1:0]         out_imm,
  output logic [6:0]              out_op,
  output logic                    out_wr,
  output logic [XLEN-1:0]         a0,
  output logic [XLEN-1:0]         a7,
  output logic                    stall
);

  localparam int AW = $clog2(NREG);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Builds the 32-bit immediate for the format implied by the opcode and
  // sign-extends it from bit 31 to XLEN.
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ins);
    logic [31:0]     i32;
    logic [XLEN-1:0] ext;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR: i32 = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:                 i32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:                i32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                                       ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         i32 = {ins[31:12], 12'b0};
      OP_JAL:                   i32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                                       ins[30:21], 1'b0};
      default:                  i32 = 32'b0;
    endcase
    ext       = {XLEN{i32[31]}};
    ext[31:0] = i32;
    return ext;
  endfunction

  logic [XLEN-1:0] r_q [NREG];
  logic [XLEN-1:0] r_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_rs1_q, out_rs1_d;
  logic [XLEN-1:0] out_rs2_q, out_rs2_d;
  logic [AW-1:0]   out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [6:0]      out_op_q, out_op_d;
  logic            out_wr_q, out_wr_d;

  logic [6:0]      op;
  logic [AW-1:0]   rs1, rs2, rd;
  logic            use_rs1, use_rs2, wr;
  logic            rs1_rdy, rs2_rdy, hazard, accept;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;

  // Decode: register fields, source usage and destination write
  always_comb begin
    op = inst[6:0];
    if (op == OP_SYSTEM) begin
      rs1 = AW'(10);
      rs2 = AW'(17);
      rd  = AW'(10);
    end else begin
      rs1 = AW'(inst[19:15]);
      rs2 = AW'(inst[24:20]);
      rd  = AW'(inst[11:7]);
    end
    use_rs1 = op inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_SYSTEM};
    use_rs2 = op inside {OP_REG, OP_STORE, OP_BRANCH, OP_SYSTEM};
    wr      = (op inside {OP_REG, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
                          OP_SYSTEM}) && (rd != '0);
    imm     = imm_gen(inst);
  end

  // Operand read with optional same-cycle forwarding from write-back
  always_comb begin
    rs1_data = (rs1 == '0) ? '0 : r_q[rs1];
    rs2_data = (rs2 == '0) ? '0 : r_q[rs2];
    if (BYPASS && wb_en && (wb_rd == rs1) && (rs1 != '0)) rs1_data = wb_data;
    if (BYPASS && wb_en && (wb_rd == rs2) && (rs2 != '0)) rs2_data = wb_data;
  end

  // Hazard and handshake
  always_comb begin
    rs1_rdy  = (rs1 == '0) || !busy_q[rs1] || (BYPASS && wb_en && (wb_rd == rs1));
    rs2_rdy  = (rs2 == '0) || !busy_q[rs2] || (BYPASS && wb_en && (wb_rd == rs2));
    hazard   = (use_rs1 && !rs1_rdy) || (use_rs2 && !rs2_rdy);
    in_ready = (!out_valid_q || out_ready) && !hazard;
    stall    = in_valid && hazard;
    accept   = in_valid && in_ready;
  end

  // Register file and scoreboard next state; a set on accept overrides a
  // clear from write-back of the same register.
  always_comb begin
    r_d    = r_q;
    busy_d = busy_q;
    if (wb_en && (wb_rd != '0)) r_d[wb_rd] = wb_data;
    if (wb_en)                  busy_d[wb_rd] = 1'b0;
    if (accept && wr)           busy_d[rd] = 1'b1;
  end

  // Output register next state; fields hold unless a new bundle is accepted
  always_comb begin
    out_valid_d = out_valid_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_rd_d    = out_rd_q;
    out_imm_d   = out_imm_q;
    out_op_d    = out_op_q;
    out_wr_d    = out_wr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_rs1_d   = rs1_data;
      out_rs2_d   = rs2_data;
      out_rd_d    = rd;
      out_imm_d   = imm;
      out_op_d    = op;
      out_wr_d    = wr;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_q[i] <= (i == 2) ? XLEN'(SP_INIT) : '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) r_q[i] <= r_d[i];
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_q    <= '0;
      out_imm_q   <= '0;
      out_op_q    <= '0;
      out_wr_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_rd_q    <= out_rd_d;
      out_imm_q   <= out_imm_d;
      out_op_q    <= out_op_d;
      out_wr_q    <= out_wr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_data = out_rs1_q;
  assign out_rs2_data = out_rs2_q;
  assign out_rd       = out_rd_q;
  assign out_imm      = out_imm_q;
  assign out_op       = out_op_q;
  assign out_wr       = out_wr_q;
  assign a0           = r_q[10];
  assign a7           = r_q[17];

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised decode stage: register file, immediate generator, write-back bypass, scoreboard and a valid/ready output pipeline register.
- Sits between fetch and execute. Accepts one instruction per cycle when no hazard is present.
- Reads both source operands and the immediate, and holds them in an output register until execute consumes them.
- Tracks pending destination writes so that read-after-write hazards stall issue until write-back.

Parameters:
- XLEN, 32, data and immediate width; must be 32 or 64.
- NREG, 32, number of architectural registers; must be a power of two, at least 32. Register addresses use the low log2(NREG) bits of the inst fields.
- SP_INIT, 65536, reset value of x2; zero-extended to XLEN.
- BYPASS, 1: write-back data is forwarded to same-cycle reads. 0: no forwarding; the read waits until the register is written.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  inst is valid
- in_ready  out  1  stage accepts inst this cycle
- inst  in  32  RV32 instruction word
- wb_en  in  1  write-back strobe
- wb_rd  in  log2(NREG)  write-back register
- wb_data  in  XLEN  write-back data
- out_valid  out  1  output bundle valid
- out_ready  in  1  execute consumes bundle
- out_rs1_data  out  XLEN  source 1 value
- out_rs2_data  out  XLEN  source 2 value
- out_rd  out  log2(NREG)  destination register
- out_imm  out  XLEN  sign-extended immediate
- out_op  out  7  opcode, inst[6:0]
- out_wr  out  1  instruction writes rd
- a0  out  XLEN  live value of x10
- a7  out  XLEN  live value of x17
- stall  out  1  in_valid high and a hazard is blocking issue

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers are 0, except x2=SP_INIT.
  - Scoreboard busy[] is all 0.
  - out_valid=0; all out_* are 0.
- Register file writes:
  - On the clk edge with wb_en=1 and wb_rd!=0: r[wb_rd]<=wb_data.
  - x0 always reads 0.
  - Write-back to a register that is not busy is legal and still writes.
- Register fields:
  - ecall (op=1110011): rs1=10, rs2=17, rd=10.
  - All other opcodes: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7].
- Source usage:
  - use_rs1=1 for op in {0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1110011}.
  - use_rs2=1 for op in {0110011, 0100011, 1100011, 1110011}.
- Destination write (out_wr):
  - wr=1 for op in {0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111, 1110011} and rd!=0.
- Immediate (sign-extended from inst[31] to XLEN):
  - I/load/jalr: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U (lui/auipc): {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode: 0.
- Hazard:
  - A source is ready when it is x0, OR busy[rs]=0, OR (BYPASS=1 and wb_en=1 and wb_rd==rs).
  - hazard = (use_rs1 and rs1 not ready) or (use_rs2 and rs2 not ready).
- Read data:
  - If BYPASS=1, wb_en=1, wb_rd==rs and rs!=0: read data = wb_data.
  - Otherwise: read data = r[rs].
- Handshake:
  - in_ready = (!out_valid | out_ready) & !hazard.
  - in_ready depends on in_valid only through hazard, never combinationally on out_valid's successor state.
  - stall = in_valid & hazard.
- Accept (in_valid & in_ready, on the clk edge):
  - The output register loads all out_* fields and out_valid<=1.
  - If wr=1: busy[rd]<=1.
- Consume without accept (out_valid & out_ready & !accept): out_valid<=0 and the bundle holds its last values.
- Back-pressure: while out_valid=1 and out_ready=0, all out_* are stable.
- Scoreboard clear:
  - wb_en=1 clears busy[wb_rd].
  - If the same edge also sets busy for the same register, the set wins (busy=1).
- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle with no hazard and out_ready held at 1.
- a0/a7 are combinational reads of r[10]/r[17], without bypass.
- Reset mid-operation: the in-flight bundle and all busy bits are discarded immediately.

Test Plan:
- Reset then read: ecall, no writes -> out_rs1_data=0, out_rs2_data=0, out_rd=10; addi x5,x2,0 -> out_rs1_data=65536, out_imm=0.
- Immediate formats: beq inst=0xFE000EE3 -> out_imm=0xFFFFFFFC; jal inst=0x0080006F -> out_imm=8; lui inst=0x123452B7 -> out_imm=0x12345000.
- RAW stall: issue addi x5 (busy[5]=1), then add x6,x5,x5 -> stall=1, in_ready=0 until wb_en,wb_rd=5,wb_data=0x77. With BYPASS=1 the add issues on that same cycle with rs1=rs2=0x77; with BYPASS=0 it issues on the next cycle.
- Back-pressure: out_ready=0 for 3 cycles after accept -> out_valid=1 and bundle unchanged, in_ready=0; out_ready=1 -> a new bundle every cycle.
- x0 handling: wb_en,wb_rd=0,wb_data=5 -> x0 still reads 0; addi x0,x0,1 -> out_wr=0 and busy unchanged.
- Simultaneous set/clear: x7 busy; wb clears x7 on the same edge an addi x7 is accepted -> busy[7]=1, so a following read of x7 stalls. Asserting rst mid-stall -> out_valid=0 and stall=0 immediately.
